// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the parametrised serial sequence detector:
//   the detector state encoding and a constant-evaluable clog2 helper
//   used to size the pattern-length field.
package seq_det_pkg;

   // Detector states: no configuration, collecting bits, history full.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      ARMED = 2'b10
   } state_t;

   // Number of bits needed to represent values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   W-bit up counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, all logic on posedge
//     reset - asynchronous active-low reset, clears q
//     inc   - add one this cycle (ignored once saturated)
//     clr   - synchronous clear, has priority over inc
//     q     - registered count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Count register: clear wins, then increment unless already at the top.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= {W{1'b0}};
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1'b1);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector
//   Moore-style serial detector for a runtime-loaded pattern of 1..MAX_LEN
//   bits with selectable overlapping / non-overlapping matching and a
//   saturating match counter.
//   Ports:
//     clk          - clock, all logic on posedge
//     reset        - asynchronous active-low reset
//     a, a_valid   - serial bit and its qualifier
//     cfg_load     - one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//     cfg_pattern  - pattern, bit cfg_len-1 is the first bit expected
//     cfg_len      - pattern length (0 disables, >MAX_LEN clamps)
//     cfg_overlap  - 1 = overlapping matches allowed
//     w            - registered single-cycle match pulse
//     match_count  - saturating match count since reset or load
//     armed        - history holds at least len counted bits
module param_seq_detector
   import seq_det_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a,
   input  logic               a_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               w,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed
);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [MAX_LEN-1:0] hist_r;
   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   fill_r;
   logic               ovl_r;
   logic               w_r;
   logic               armed_r;

   logic [LEN_W-1:0]   len_clamp_s;
   logic               accept_s;
   logic [MAX_LEN-1:0] hist_nxt_s;
   logic [LEN_W-1:0]   fill_inc_s;
   logic [MAX_LEN-1:0] mask_s;
   logic               match_s;
   logic               w_nxt_s;
   logic               armed_nxt_s;

   // Datapath decode: accepted bit, updated history, fill count and compare.
   // The compare looks at the updated history so the filling bit can match.
   always_comb begin
      len_clamp_s = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      accept_s    = a_valid && !cfg_load && ((state_r == FILL) || (state_r == ARMED));
      hist_nxt_s  = {hist_r[MAX_LEN-2:0], a};
      if (fill_r >= len_r) begin
         fill_inc_s = len_r;
      end else begin
         fill_inc_s = fill_r + LEN_W'(1'b1);
      end
      mask_s = {MAX_LEN{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_s[i] = (LEN_W'(i) < len_r);
      end
      match_s = accept_s && (fill_inc_s >= len_r) &&
                (((hist_nxt_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
   end

   // Next-state logic; a load overrides everything else that cycle.
   always_comb begin
      state_nxt_s = state_r;
      if (cfg_load) begin
         if (len_clamp_s == {LEN_W{1'b0}}) begin
            state_nxt_s = IDLE;
         end else begin
            state_nxt_s = FILL;
         end
      end else begin
         case (state_r)
            IDLE: state_nxt_s = IDLE;
            FILL, ARMED: begin
               if (!accept_s) begin
                  state_nxt_s = state_r;
               end else if (match_s && !ovl_r) begin
                  state_nxt_s = FILL;
               end else if (fill_inc_s >= len_r) begin
                  state_nxt_s = ARMED;
               end else begin
                  state_nxt_s = FILL;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Output decode, registered alongside the state so outputs are flops.
   always_comb begin
      w_nxt_s     = match_s;
      armed_nxt_s = (state_nxt_s == ARMED);
   end

   // State, configuration, history and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         hist_r  <= {MAX_LEN{1'b0}};
         pat_r   <= {MAX_LEN{1'b0}};
         len_r   <= {LEN_W{1'b0}};
         fill_r  <= {LEN_W{1'b0}};
         ovl_r   <= 1'b0;
         w_r     <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         w_r     <= w_nxt_s;
         armed_r <= armed_nxt_s;
         if (cfg_load) begin
            hist_r <= {MAX_LEN{1'b0}};
            pat_r  <= cfg_pattern;
            len_r  <= len_clamp_s;
            fill_r <= {LEN_W{1'b0}};
            ovl_r  <= cfg_overlap;
         end else if (accept_s) begin
            hist_r <= hist_nxt_s;
            // Non-overlapping: keep the history bits but stop counting them.
            fill_r <= (match_s && !ovl_r) ? {LEN_W{1'b0}} : fill_inc_s;
         end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match_s),
      .clr   (cfg_load),
      .q     (match_count)
   );

   assign w     = w_r;
   assign armed = armed_r;

endmodule

// File: doc/param_seq_detector.md
# param_seq_detector

Parametrised Moore-style serial sequence detector, successor to the fixed-pattern detector. It compares a runtime-loaded pattern of 1..MAX_LEN bits against a serial bit stream qualified by a valid strobe. Overlapping or non-overlapping match mode is selected at runtime, and matches are counted in a saturating counter. It sits on a serial input line and gives downstream control logic a single-cycle match pulse plus a running match count.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived, not overridden).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- a  in  1  serial data bit.
- a_valid  in  1  a is sampled on posedges where a_valid=1.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit expected, bit 0 the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- w  out  1  registered match pulse.
- match_count  out  CNT_W  saturating number of matches since the last reset or load.
- armed  out  1  high when the history holds at least len valid bits.

## Operation
- State register has three states: IDLE (no valid configuration), FILL (fewer than len bits collected), ARMED (history full).
- Reset (reset=0, asynchronous) forces the following: state IDLE; w=0, match_count=0, armed=0; history, fill counter, pattern, len and overlap all cleared.
- cfg_load in any state:
  - latches the configuration; clears history, the fill counter, w and match_count.
  - cfg_len=0 sends the block to IDLE (disabled).
  - cfg_len>MAX_LEN is clamped to MAX_LEN.
  - any other value sends the block to FILL.
- cfg_load and a_valid in the same cycle: the load wins and the bit is discarded.
- IDLE: a_valid is ignored and w stays 0.
- Accepted bit: the history shifts left with the new bit entering at bit 0; the fill counter increments, saturating at len.
- FILL→ARMED when the fill counter reaches len. The compare is done on the updated history, so the bit that fills the history can itself produce a match.
- Match condition: history[len-1:0] == pattern[len-1:0] with fill ≥ len. On a match:
  - w=1 for exactly one cycle.
  - match_count increments, saturating at 2^CNT_W−1.
  - overlap=1: stay ARMED.
  - overlap=0: fill counter cleared, go to FILL (history bits are kept but not counted).
- No accepted bit in a cycle: w=0 and state unchanged.
- armed = (state == ARMED).

## Timing
- Latency: w and match_count update on the same posedge that samples the completing bit, and are visible for the following cycle.
- w never stays high two consecutive cycles unless two consecutive accepted bits each complete a match.
  - Example: overlap=1, len=2, pattern 2'b11, stream 1,1,1 gives w high on bits 2 and 3.
- After cfg_load, the earliest possible match is len accepted bits later.
- Asynchronous reset takes effect immediately with no clock edge required. Deassertion is synchronised externally.
- Equivalence: len=3, pattern 3'b110, overlap=1 reproduces the legacy 110 detector timing.

## Structure
- Shared package seq_det_pkg holds:
  - state typedef/constants: IDLE=2'b00, FILL=2'b01, ARMED=2'b10.
  - the clog2 helper function.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output q), instantiated for match_count.
- The compare uses a mask built from len; no per-length case statements.

## Test plan
- Reset, then load pattern 3'b110, len 3, overlap 1; stream 0,1,1,0 → w=1 only in the cycle after bit 4 is sampled; match_count=1; armed=1 from bit 3 onward.
- Load 4'b1010, len 4, stream 1,0,1,0,1,0,1,0:
  - overlap=1 → w after bits 4, 6 and 8; match_count=3.
  - overlap=0 → w after bits 4 and 8; match_count=2.
- Same stream as 3'b110 case with a_valid=0 for two cycles between each bit and a toggling during the gaps → identical w/match_count results to the gap-free run.
- Mid-stream cfg_load (pattern 2'b01, len 2) asserted together with a_valid=1, a=1 → that bit is discarded; match_count=0; armed=0; next stream 0,1 → w=1, count=1.
- CNT_W=2, pattern 2'b11, len 2, overlap 1, six 1-bits → five w pulses; match_count stays at 3 after the third match.
- Assert reset asynchronously mid-FILL (between edges) → w, match_count and armed read 0 before the next edge. Afterwards load cfg_len=0 with stream 1,1,0 → w never asserts and the block stays IDLE.
